// File: rtl/uart_rx_hex_display_pkg.sv
// Shared display constants and hex-to-segment table for the UART 7-seg design.
// Used by both the receive-side and transmit-side display paths.
package uart_rx_hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int DEF_REFRESH_DIV = 50000;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_seg(
    input logic [3:0] n
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/uart_rx_hex_display_hex_to_7seg.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Ports: i_nib (4-bit nibble in), o_seg (segments {g..a}, active-low).
module hex_to_7seg
  import uart_rx_hex_display_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_seg(i_nib);

endmodule

// File: rtl/uart_rx_hex_display.sv
// UART receive byte history shown as hex on a multiplexed common-anode display.
// Ports: clk_50Mhz, rst (async high), rx_ready/rx_data in; seg, dp, an, act_led, byte_count out.
module uart_rx_hex_display
  import uart_rx_hex_display_pkg::*;
#(
  parameter int DBITS       = 8,
  parameter int NDIG        = 4,
  parameter int REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int ACT_CYCLES  = 2500000
) (
  input  logic             clk_50Mhz,
  input  logic             rst,
  input  logic             rx_ready,
  input  logic [DBITS-1:0] rx_data,
  output logic [6:0]       seg,
  output logic             dp,
  output logic [NDIG-1:0]  an,
  output logic             act_led,
  output logic [7:0]       byte_count
);

  localparam int NB = NDIG / 2;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NDIG);
  localparam int SW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(ACT_CYCLES + 1);

  logic [NB-1:0][DBITS-1:0] r_hist;
  logic [NB-1:0]            r_valid;
  logic [PW-1:0]            r_pre;
  logic [DW-1:0]            r_dig;
  logic [AW-1:0]            r_act;
  logic [7:0]               r_cnt;
  logic [6:0]               r_seg;
  logic                     r_dp;
  logic [NDIG-1:0]          r_an;

  logic                     w_wrap;
  logic                     w_dig_last;
  logic [SW-1:0]            w_slot;
  logic [DBITS-1:0]         w_byte;
  logic [3:0]               w_nib;
  logic                     w_vld;
  logic [6:0]               w_hex;
  logic [NDIG-1:0]          w_an;
  logic                     w_dp;

  assign w_wrap     = (r_pre == PW'(REFRESH_DIV - 1));
  assign w_dig_last = (r_dig == DW'(NDIG - 1));
  assign w_slot     = SW'(r_dig >> 1);
  assign w_byte     = r_hist[w_slot];
  assign w_vld      = r_valid[w_slot];
  assign w_nib      = r_dig[0] ? w_byte[7:4] : w_byte[3:0];
  assign w_an       = ~(NDIG'(1) << r_dig);
  // Separator dot sits on the low nibble of every older byte.
  assign w_dp       = ~(w_vld && (w_slot != '0) && !r_dig[0]);

  hex_to_7seg u_hex (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_hist  <= '0;
      r_valid <= '0;
      r_cnt   <= '0;
    end else if (rx_ready) begin
      for (int k = NB - 1; k > 0; k--) begin
        r_hist[k]  <= r_hist[k-1];
        r_valid[k] <= r_valid[k-1];
      end
      r_hist[0]  <= rx_data;
      r_valid[0] <= 1'b1;
      r_cnt      <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_act <= '0;
    end else if (rx_ready) begin
      r_act <= AW'(ACT_CYCLES);
    end else if (r_act != '0) begin
      r_act <= r_act - 1'b1;
    end
  end

  // Outputs latch from the pre-capture history on the wrap cycle.
  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
      r_dig <= '0;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
      r_an  <= '1;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_dig <= w_dig_last ? '0 : r_dig + 1'b1;
      r_an  <= w_an;
      r_seg <= w_vld ? w_hex : SEG_BLANK;
      r_dp  <= w_dp;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign act_led    = (r_act != '0);
  assign byte_count = r_cnt;

endmodule

// File: tb/tb_uart_rx_hex_display.sv
// Directed self-checking bench for uart_rx_hex_display.
// Small refresh/activity constants keep scan periods short.
module tb_uart_rx_hex_display;

  logic       clk;
  logic       rst;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       act_led;
  logic [7:0] byte_count;

  int n_chk;
  int n_pass;

  uart_rx_hex_display #(
    .DBITS       (8),
    .NDIG        (4),
    .REFRESH_DIV (4),
    .ACT_CYCLES  (10)
  ) dut (
    .clk_50Mhz  (clk),
    .rst        (rst),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .act_led    (act_led),
    .byte_count (byte_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Wait for a fresh visit of digit d (skip a visit already showing).
  task automatic wait_dig(input int d);
    logic [3:0] t;
    int n;
    t = ~(4'b0001 << d);
    n = 0;
    while (an === t && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (an !== t && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("an_reach", {28'd0, an}, {28'd0, t});
  endtask

  task automatic show(
    input string      tag,
    input int         d,
    input logic [6:0] s,
    input logic       p
  );
    wait_dig(d);
    chk({tag, "_seg"}, {25'd0, seg}, {25'd0, s});
    chk({tag, "_dp"}, {31'd0, dp}, {31'd0, p});
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int hi;
    int drops;
    n_chk    = 0;
    n_pass   = 0;
    rst      = 1'b1;
    rx_ready = 1'b0;
    rx_data  = 8'h00;

    // 1: reset values, then blank scan
    #1;
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_act", {31'd0, act_led}, 32'h0);
    chk("rst_cnt", {24'd0, byte_count}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("an_pre", {28'd0, an}, 32'hF);
    @(posedge clk);
    @(negedge clk);
    chk("an_first", {28'd0, an}, 32'hE);
    chk("seg_first", {25'd0, seg}, 32'h7F);
    for (int i = 1; i < 4; i++) begin
      repeat (4) @(negedge clk);
      chk("an_scan", {28'd0, an}, {28'd0, ~(4'b0001 << i)});
      chk("seg_scan", {25'd0, seg}, 32'h7F);
    end

    // 2: single byte A5
    send(8'hA5);
    chk("cnt_1", {24'd0, byte_count}, 32'h1);
    hi = 0;
    while (act_led && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    chk("act_len", hi, 10);
    show("t2_d0", 0, 7'h12, 1'b1);
    show("t2_d1", 1, 7'h08, 1'b1);
    show("t2_d2", 2, 7'h7F, 1'b1);
    show("t2_d3", 3, 7'h7F, 1'b1);

    // 3: three bytes, oldest dropped
    do_reset();
    send(8'h3C);
    send(8'h7E);
    send(8'h01);
    chk("cnt_3", {24'd0, byte_count}, 32'h3);
    show("t3_d0", 0, 7'h79, 1'b1);
    show("t3_d1", 1, 7'h40, 1'b1);
    show("t3_d2", 2, 7'h06, 1'b0);
    show("t3_d3", 3, 7'h78, 1'b1);

    // 4: back-to-back strobe
    do_reset();
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = 8'h11;
    @(negedge clk);
    rx_data  = 8'h22;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("cnt_b2b", {24'd0, byte_count}, 32'h2);
    show("t4_d0", 0, 7'h24, 1'b1);
    show("t4_d1", 1, 7'h24, 1'b1);
    show("t4_d2", 2, 7'h79, 1'b0);
    show("t4_d3", 3, 7'h79, 1'b1);

    // 5: 256 pulses, counter wrap and retrigger
    do_reset();
    drops = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      rx_ready = 1'b1;
      rx_data  = 8'(i);
      @(negedge clk);
      rx_ready = 1'b0;
      if (!act_led) drops++;
      if (i == 254) chk("cnt_ff", {24'd0, byte_count}, 32'hFF);
      repeat (3) begin
        @(negedge clk);
        if (!act_led) drops++;
      end
    end
    chk("cnt_wrap", {24'd0, byte_count}, 32'h0);
    chk("act_drops", drops, 0);

    // 6: async reset mid-scan with full history
    show("t6_d2", 2, 7'h06, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_seg", {25'd0, seg}, 32'h7F);
    chk("ar_dp", {31'd0, dp}, 32'h1);
    chk("ar_an", {28'd0, an}, 32'hF);
    chk("ar_act", {31'd0, act_led}, 32'h0);
    chk("ar_cnt", {24'd0, byte_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    show("t6_d0", 0, 7'h7F, 1'b1);
    show("t6_d1", 1, 7'h7F, 1'b1);
    show("t6_d2b", 2, 7'h7F, 1'b1);
    show("t6_d3", 3, 7'h7F, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
